fetch: RTL and testbench

Instruction fetch stage of the Pillar core, sitting directly upstream of `decode`. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched word on `ir_o` with a stage code for `decode`'s `stage_i`. Accepts PC redirects from execute and discards any in-flight fetch they overtake.

---
 rtl/fetch.sv | 202 ++++++++++++++++++++
 tb/tb_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and
// hands them to decode. Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirects.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        ir_valid_o,
  output logic [2:0]  stage_o,
  input  logic        advance_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fault_o
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_KILL, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_KILL, S_HOLD} state_t;
`endif

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] addr_r, addr_s;
  logic        req_r, req_s;
  logic [31:0] ir_r, ir_s;
  logic        valid_r, valid_s;
  logic [2:0]  stage_r, stage_s;
  logic [31:0] target_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_r, fault_s;
  logic        pend_r, pend_s;
  logic        bad_s;
  assign target_s = redirect_pc_i;
  assign bad_s    = |redirect_pc_i[1:0];
  assign fault_o  = fault_r;
`else
  assign target_s = redirect_pc_i & ~32'd3;
  assign fault_o  = 1'b0;
`endif

  assign mem_addr_o = addr_r;
  assign mem_req_o  = req_r;
  assign ir_o       = ir_r;
  assign pc_o       = pc_r;
  assign ir_valid_o = valid_r;
  assign stage_o    = stage_r;

  // Next-state and next-output logic; redirect outranks ack and advance everywhere.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    addr_s  = addr_r;
    req_s   = req_r;
    ir_s    = ir_r;
    valid_s = valid_r;
    stage_s = stage_r;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_s = fault_r;
    pend_s  = pend_r;
`endif
    case (state_r)
      S_IDLE, S_HOLD: begin
        if (redirect_i) begin
          pc_s    = target_s;
          ir_s    = NOP_INSN;
          valid_s = 1'b0;
          stage_s = 3'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (bad_s) begin
            state_s = S_FAULT;
            fault_s = 1'b1;
          end else begin
`endif
            state_s = S_REQ;
            addr_s  = target_s;
            req_s   = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          end
`endif
        end else if (state_r == S_IDLE) begin
          state_s = S_REQ;
          addr_s  = pc_r;
          req_s   = 1'b1;
        end else if (advance_i) begin
          state_s = S_REQ;
          pc_s    = pc_r + 32'd4;
          addr_s  = pc_r + 32'd4;
          req_s   = 1'b1;
          ir_s    = NOP_INSN;
          valid_s = 1'b0;
          stage_s = 3'd0;
        end else begin
          state_s = state_r;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          pc_s = target_s;
          if (mem_ack_i) begin
            req_s   = 1'b0;
            state_s = S_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bad_s) begin
              state_s = S_FAULT;
              fault_s = 1'b1;
            end else begin
              state_s = S_IDLE;
            end
`endif
          end else begin
            // The bus request cannot be withdrawn, so wait it out in KILL.
            state_s = S_KILL;
`ifdef FETCH_MISALIGN_TRAP_EN
            pend_s  = bad_s;
`endif
          end
        end else if (mem_ack_i) begin
          state_s = S_HOLD;
          ir_s    = mem_rdata_i;
          valid_s = 1'b1;
          stage_s = 3'd1;
          req_s   = 1'b0;
        end else begin
          state_s = S_REQ;
        end
      end
      S_KILL: begin
        if (redirect_i) begin
          pc_s = target_s;
`ifdef FETCH_MISALIGN_TRAP_EN
          pend_s = bad_s;
`endif
        end else begin
          pc_s = pc_r;
        end
        if (mem_ack_i) begin
          req_s   = 1'b0;
          state_s = S_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pend_s) begin
            state_s = S_FAULT;
            fault_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
`endif
        end else begin
          state_s = S_KILL;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: begin
        state_s = S_FAULT;
        req_s   = 1'b0;
      end
`endif
      default: begin
        state_s = S_IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      req_r   <= 1'b0;
      ir_r    <= NOP_INSN;
      valid_r <= 1'b0;
      stage_r <= 3'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_r <= 1'b0;
      pend_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      addr_r  <= addr_s;
      req_r   <= req_s;
      ir_r    <= ir_s;
      valid_r <= valid_s;
      stage_r <= stage_s;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_r <= fault_s;
      pend_r  <= pend_s;
`endif
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized traffic checked
// against a transaction-level model of the PC sequence and the memory contents.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic        ir_valid_o;
  logic [2:0]  stage_o;
  logic        advance_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fault_o;

  fetch dut (
    .clk(clk), .reset(reset), .mem_addr_o(mem_addr_o), .mem_req_o(mem_req_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .ir_o(ir_o), .pc_o(pc_o),
    .ir_valid_o(ir_valid_o), .stage_o(stage_o), .advance_i(advance_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic        killed;
  // Memory responder state
  int          wait_mode;
  int          waits_left;
  logic        req_active;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0020_8033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc     = 32'h0;
    exp_valid  = 1'b0;
    killed     = 1'b0;
    req_active = 1'b0;
  endtask

  // One clock cycle: respond as memory, clock, advance the model, check outputs.
  task automatic tick();
    logic s_req, s_ack;
    logic [31:0] s_addr;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (mem_req_o) begin
      if (!req_active) begin
        req_active = 1'b1;
        waits_left = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      end
      if (waits_left == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_word(mem_addr_o);
        req_active  = 1'b0;
      end else begin
        waits_left--;
      end
    end
    s_req = mem_req_o; s_ack = mem_ack_i; s_addr = mem_addr_o;
    @(posedge clk);
    if (s_req && s_ack) begin
      exp_valid = !(redirect_i || killed);
      killed    = 1'b0;
    end else if (redirect_i) begin
      exp_valid = 1'b0;
      if (s_req) killed = 1'b1;
    end else if (advance_i && exp_valid) begin
      exp_valid = 1'b0;
    end
    if (redirect_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc = redirect_pc_i;
`else
      exp_pc = {redirect_pc_i[31:2], 2'b00};
`endif
    end else if (advance_i && ir_valid_o === 1'b1 && !(s_req && s_ack)) begin
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clk);
    chk("pc", pc_o, exp_pc);
    chk("valid", {31'd0, ir_valid_o}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("ir", ir_o, mem_word(exp_pc));
      chk("stage_dec", {29'd0, stage_o}, 32'd1);
    end else begin
      chk("ir_nop", ir_o, NOP);
      chk("stage_fetch", {29'd0, stage_o}, 32'd0);
    end
    if (s_req && !s_ack) begin
      chk("req_hold", {31'd0, mem_req_o}, 32'd1);
      chk("addr_stable", mem_addr_o, s_addr);
    end else if (mem_req_o) begin
      chk("req_addr", mem_addr_o, exp_pc);
    end else begin
      chk("req_low_addr", {31'd0, mem_req_o}, 32'd0);
    end
`ifndef FETCH_MISALIGN_TRAP_EN
    chk("fault_tied", {31'd0, fault_o}, 32'd0);
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    advance_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    wait_mode = 0; waits_left = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_ir", ir_o, NOP);
    chk("rst_valid", {31'd0, ir_valid_o}, 32'd0);
    chk("rst_stage", {29'd0, stage_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_fault", {31'd0, fault_o}, 32'd0);
    reset = 1'b0;

    // First fetch from 0 with zero-wait memory
    n = 0;
    while (ir_valid_o !== 1'b1 && n < 10) begin tick(); n++; end
    chk("first_ir", ir_o, 32'h0020_8033);
    chk("first_pc", pc_o, 32'h0);
    chk("first_addr", mem_addr_o, 32'h0);
    chk("first_stage", {29'd0, stage_o}, 32'd1);

    // Two wait states, advance held high
    wait_mode = 2; advance_i = 1'b1;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h8) && n < 30) begin tick(); n++; end
    chk("reach_8", mem_addr_o, 32'h8);

    // Redirect to 0x100 while a slow request is pending
    wait_mode = 3;
    n = 0;
    while (!(mem_req_o && !req_active) && n < 30) begin tick(); n++; end
    redirect_i = 1'b1; redirect_pc_i = 32'h100; advance_i = 1'b0;
    tick();
    redirect_i = 1'b0;
    n = 0;
    while (ir_valid_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("kill_pc", pc_o, 32'h100);
    chk("kill_ir", ir_o, mem_word(32'h100));

    // Redirect coinciding with the ack
    wait_mode = 0; advance_i = 1'b1;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 10) begin tick(); n++; end
    redirect_i = 1'b1; redirect_pc_i = 32'h200; advance_i = 1'b0;
    tick();
    redirect_i = 1'b0;
    chk("drop_req_low", {31'd0, mem_req_o}, 32'd0);
    tick();
    chk("drop_req_high", {31'd0, mem_req_o}, 32'd1);
    chk("drop_addr", mem_addr_o, 32'h200);

    // PC wraps from the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    n = 0;
    while (ir_valid_o !== 1'b1 && n < 10) begin tick(); n++; end
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    advance_i = 1'b1;
    tick();
    chk("wrap_req", {31'd0, mem_req_o}, 32'd1);
    chk("wrap_addr", mem_addr_o, 32'h0);

    // Randomized traffic
    wait_mode = -1;
    for (int i = 0; i < 400; i++) begin
      advance_i  = ($urandom_range(0, 9) < 7);
      redirect_i = ($urandom_range(0, 11) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_pc_i = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc_i = $urandom;
`endif
      tick();
    end
    redirect_i = 1'b0; advance_i = 1'b1;

    // Reset in the middle of a request
    n = 0;
    while (mem_req_o !== 1'b1 && n < 10) begin tick(); n++; end
    reset = 1'b1;
    #1;
    chk("async_req", {31'd0, mem_req_o}, 32'd0);
    chk("async_pc", pc_o, 32'h0);
    chk("async_valid", {31'd0, ir_valid_o}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Misaligned redirect
    advance_i = 1'b0; wait_mode = 0;
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n = 0;
    while (fault_o !== 1'b1 && n < 10) begin tick(); n++; end
    chk("fault_set", {31'd0, fault_o}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("fault_noreq", {31'd0, mem_req_o}, 32'd0);
    end
    chk("fault_pc", pc_o, 32'h102);
`else
    n = 0;
    while (mem_req_o !== 1'b1 && n < 10) begin tick(); n++; end
    chk("align_addr", mem_addr_o, 32'h100);
    chk("align_fault", {31'd0, fault_o}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
